// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg
// Shared definitions for the buffered UART transmitter:
//   - 2-bit FSM state encodings (IDLE=00, START=01, DATA=10, STOP=11)
//   - line levels of the start and stop bits
//   - default bit period (100 MHz / 115200)
//   - debug struct exposing FSM state, bit index, bit counter and FIFO fill
package uart_tx_buffered_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef struct packed {
    logic [1:0]  state;
    logic [2:0]  bit_idx;
    logic [15:0] bit_cnt;
    logic [7:0]  fifo_count;
  } dbg_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if
// Host-side bundle of the buffered UART transmitter.
//   data         byte to enqueue
//   load         enqueue strobe
//   clr_overflow synchronous clear of the sticky overflow flag
//   full         FIFO holds FIFO_DEPTH entries
//   busy         a frame is in progress
//   idle         FIFO empty and not busy
//   overflow     sticky: a load arrived while full
//   dbg          FSM / counter / FIFO fill snapshot
// Handshake: load is a single-cycle strobe with no ready return path. A load
// is accepted at a rising edge iff full (registered, before that edge) is 0;
// otherwise the byte is dropped and overflow is set.
interface uart_tx_buffered_if;
  import uart_tx_buffered_pkg::*;

  logic [7:0] data;
  logic       load;
  logic       clr_overflow;
  logic       full;
  logic       busy;
  logic       idle;
  logic       overflow;
  dbg_t       dbg;

  modport master (
    output data, load, clr_overflow,
    input  full, busy, idle, overflow, dbg
  );

  modport slave (
    input  data, load, clr_overflow,
    output full, busy, idle, overflow, dbg
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO with registered count.
//   clk, l_ready_reset  clock, async active-high reset
//   push_i, data_i      write strobe and data (ignored while full)
//   pop_i               read strobe (ignored while empty); data_o is the head
//   full_o, empty_o     derived from the registered count
//   count_o             number of stored entries
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              l_ready_reset,
  input  logic              push_i,
  input  logic [7:0]        data_i,
  input  logic              pop_i,
  output logic [7:0]        data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are ADDR_W bits wide, so wrap modulo FIFO_DEPTH is implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge l_ready_reset) begin
    if (l_ready_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes pushed through the host interface are
// queued in uart_tx_fifo and sent on tx_o as start bit, 8 data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks. Frames run back-to-back while the
// FIFO holds data.
//   clk            system clock, rising edge
//   l_ready_reset  async active-high reset; aborts any frame, tx_o goes high
//   host           uart_tx_buffered_if.slave (data/load/clr_overflow in,
//                  full/busy/idle/overflow/dbg out)
//   tx_o           registered serial line, idles high
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic                   clk,
  input  logic                   l_ready_reset,
  uart_tx_buffered_if.slave      host,
  output logic                   tx_o
);

  localparam logic [15:0] TC = 16'(CLKS_PER_BIT - 1);

  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            busy_q;
  logic            overflow_q, overflow_d;

  logic            fifo_full, fifo_empty, pop;
  logic [7:0]      fifo_head;
  logic [ADDR_W:0] fifo_count;
  logic            tc;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk           (clk),
    .l_ready_reset (l_ready_reset),
    .push_i        (host.load),
    .data_i        (host.data),
    .pop_i         (pop),
    .data_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .count_o       (fifo_count)
  );

  assign tc = (cnt_q == TC);

  // tx_d is the line value of the state being entered, so tx_q changes on the
  // same edge as the state and the output stays a clean flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = STOP_BIT;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_head;
          idx_d   = '0;
          state_d = ST_START;
          tx_d    = START_BIT;
        end
      end
      ST_START: begin
        if (tc) begin
          cnt_d   = '0;
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
          end else begin
            tx_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          cnt_d = '0;
          // Chain straight into the next start bit: no idle clock between frames.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_head;
            idx_d   = '0;
            state_d = ST_START;
            tx_d    = START_BIT;
          end else begin
            state_d = ST_IDLE;
            tx_d    = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = STOP_BIT;
      end
    endcase
  end

  // A dropped load sets the flag even when a clear arrives on the same edge.
  always_comb begin
    overflow_d = overflow_q;
    if (host.load && fifo_full) overflow_d = 1'b1;
    else if (host.clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge l_ready_reset) begin
    if (l_ready_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      tx_q       <= STOP_BIT;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= overflow_d;
    end
  end

  assign tx_o          = tx_q;
  assign host.full     = fifo_full;
  assign host.busy     = busy_q;
  assign host.idle     = fifo_empty && !busy_q;
  assign host.overflow = overflow_q;

  assign host.dbg.state      = state_q;
  assign host.dbg.bit_idx    = idx_q;
  assign host.dbg.bit_cnt    = cnt_q;
  assign host.dbg.fifo_count = 8'(fifo_count);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4. Accepted
// bytes go into exp_q; a line monitor decodes every frame on tx_o, sample by
// sample, against the ideal 8N1 waveform of the byte at the head of exp_q.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic l_ready_reset;
  logic tx_o;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .clk           (clk),
    .l_ready_reset (l_ready_reset),
    .host          (bus),
    .tx_o          (tx_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total  = 0;
  int bad    = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  // Ideal frame: index 0 start, 1..8 data LSB first, 9 stop; each level
  // must hold for CPB consecutive samples and busy must be high throughout.
  bit         m_active = 1'b0;
  bit         m_have;
  bit         m_err;
  int         m_k;
  logic [9:0] m_line;
  logic [7:0] m_got;

  initial begin
    forever begin
      @(negedge clk);
      if (l_ready_reset === 1'b1) begin
        m_active = 1'b0;
      end else begin
        if (!m_active && tx_o === 1'b0) begin
          m_active = 1'b1;
          m_k      = 0;
          m_err    = 1'b0;
          m_got    = '0;
          if (exp_q.size() > 0) begin
            m_line = {STOP_BIT, exp_q.pop_front(), START_BIT};
            m_have = 1'b1;
          end else begin
            m_line = 10'h3ff;
            m_have = 1'b0;
          end
        end
        if (m_active) begin
          if (tx_o !== m_line[m_k / CPB] || bus.busy !== 1'b1) m_err = 1'b1;
          if (m_k / CPB >= 1 && m_k / CPB <= 8 && m_k % CPB == CPB / 2)
            m_got[m_k / CPB - 1] = tx_o;
          m_k++;
          if (m_k == FRAME) begin
            m_active = 1'b0;
            frames++;
            total++;
            if (!m_have || m_err) begin
              bad++;
              $display("FAIL frame: got byte %02h expected %02h (queued=%0d, timing/busy error=%0d)",
                       m_got, m_line[8:1], m_have, m_err);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a negedge; the byte is sampled at the following rising edge.
  task automatic load_byte(input logic [7:0] b);
    bus.data = b;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_not_full(input string name);
    int n = 0;
    while (bus.full === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_not_full"}, {31'd0, bus.full}, 32'd0);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (bus.idle !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, {31'd0, bus.idle}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    int w = 0;
    while (bus.busy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  int n_busy;
  int f0;
  logic [7:0] b;
  logic [7:0] lb_bytes [3];

  initial begin
    l_ready_reset    = 1'b1;
    bus.data         = '0;
    bus.load         = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    l_ready_reset = 1'b0;

    // reset state
    check("rst_tx",       {31'd0, tx_o},         32'd1);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    check("rst_full",     {31'd0, bus.full},     32'd0);
    check("rst_idle",     {31'd0, bus.idle},     32'd1);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);

    // single byte 0xA5: line falls after the second edge following the load
    exp_q.push_back(8'hA5);
    load_byte(8'hA5);
    check("lat_tx_e",     {31'd0, tx_o},     32'd1);
    check("lat_idle_e",   {31'd0, bus.idle}, 32'd0);
    @(negedge clk);
    check("lat_tx_e1",    {31'd0, tx_o},     32'd0);
    check("lat_busy_e1",  {31'd0, bus.busy}, 32'd1);
    count_busy(n_busy);
    check("single_busy_len", n_busy, FRAME);
    check("single_idle_after", {31'd0, bus.idle}, 32'd1);
    repeat (2) @(negedge clk);

    // back-to-back 0x00 then 0xFF: one unbroken busy stretch of two frames
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    bus.data = 8'h00;
    bus.load = 1'b1;
    @(negedge clk);
    bus.data = 8'hFF;
    @(negedge clk);
    bus.load = 1'b0;
    count_busy(n_busy);
    check("b2b_busy_len", n_busy, 2 * FRAME);
    wait_quiet("b2b");

    // overflow: from idle, the first byte moves into the shifter one clock
    // after it arrives, so DEPTH+1 consecutive loads fit and the rest drop.
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < DEPTH + 1) exp_q.push_back(b);
      load_byte(b);
    end
    check("ovf_set",  {31'd0, bus.overflow}, 32'd1);
    check("ovf_full", {31'd0, bus.full},     32'd1);
    // dropped load and clear on the same edge: the flag stays set
    bus.data         = 8'hEE;
    bus.load         = 1'b1;
    bus.clr_overflow = 1'b1;
    @(negedge clk);
    bus.load         = 1'b0;
    bus.clr_overflow = 1'b0;
    check("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
    bus.clr_overflow = 1'b1;
    @(negedge clk);
    bus.clr_overflow = 1'b0;
    check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    wait_quiet("ovf");
    check("ovf_frames", frames - f0, DEPTH + 1);

    // wrap-around: 12 sequential bytes, each offered only while not full
    for (int i = 1; i <= 12; i++) begin
      wait_not_full("wrap");
      exp_q.push_back(8'(i));
      load_byte(8'(i));
    end
    wait_quiet("wrap");
    check("wrap_no_ovf", {31'd0, bus.overflow}, 32'd0);

    // known patterns, then random bytes with random spacing
    lb_bytes[0] = 8'h55;
    lb_bytes[1] = 8'h80;
    lb_bytes[2] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      wait_not_full("pat");
      exp_q.push_back(lb_bytes[i]);
      load_byte(lb_bytes[i]);
    end
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      wait_not_full("rnd");
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      load_byte(b);
    end
    wait_quiet("rnd");

    // reset during data bit 3 of 0xC3 (bit 3 is 0, so the line is low)
    exp_q.push_back(8'hC3);
    load_byte(8'hC3);
    repeat (18) @(negedge clk);
    check("mid_state",   {30'd0, bus.dbg.state},   {30'd0, ST_DATA});
    check("mid_bit_idx", {29'd0, bus.dbg.bit_idx}, 32'd3);
    check("mid_tx_low",  {31'd0, tx_o},            32'd0);
    #1 l_ready_reset = 1'b1;
    #1;
    check("mid_rst_tx",   {31'd0, tx_o},     32'd1);
    check("mid_rst_idle", {31'd0, bus.idle}, 32'd1);
    check("mid_rst_full", {31'd0, bus.full}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    l_ready_reset = 1'b0;
    f0 = frames;
    exp_q.push_back(8'h3C);
    load_byte(8'h3C);
    wait_quiet("post_rst");
    check("post_rst_frames", frames - f0, 1);

    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter with internal bit-timing counter; the transmit-side counterpart to uart_receive.
- Host logic pushes bytes into a small FIFO with a single-cycle strobe.
- The block serialises each byte onto tx_o as start bit, 8 data bits LSB first, then stop bit.
- Frames are sent back-to-back with no idle gap while the FIFO holds data; no dependency on clock_divider or serializer.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- l_ready_reset  in  1  reset; asynchronous, active-high.
- data  in  8  byte to enqueue.
- load  in  1  enqueue strobe, sampled on the rising edge of clk.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- busy  out  1  a frame is in progress (FSM not IDLE).
- idle  out  1  FIFO empty and not busy.
- overflow  out  1  sticky: a load arrived while full.
- clr_overflow  in  1  synchronous clear of overflow.
- tx_o  out  1  serial line; idles high.

Behaviour:
- Reset (async):
  - tx_o=1, busy=0, full=0, idle=1, overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; bit counter = 0.
  - Reset mid-frame aborts the frame immediately; tx_o returns high without waiting for clk.
- FIFO write:
  - load && !full at an edge stores data; count increments.
  - full is evaluated from the registered count before the edge. A load while full is dropped even if a pop occurs the same edge, and sets overflow.
  - Simultaneous write and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set by a dropped load; cleared by clr_overflow.
  - If set and clear occur on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - Each non-IDLE state holds its line value for exactly CLKS_PER_BIT clocks, counted by a 16-bit counter running 0..CLKS_PER_BIT-1.
- IDLE:
  - tx_o=1.
  - If FIFO not empty: pop the head into shift register sh[7:0], bit index=0, go to START.
- START: tx_o=0; when the counter reaches terminal count, go to DATA.
- DATA:
  - tx_o=sh[0].
  - At terminal count: shift sh right; increment index. After index 7, go to STOP.
- STOP:
  - tx_o=1.
  - At terminal count: if FIFO not empty, pop and go directly to START (no extra idle clock); else go to IDLE.
- Outputs and timing:
  - tx_o is a registered output (glitch-free).
  - busy = (state != IDLE), registered with the state.
- Latency:
  - Load at edge E into an empty, idle block: count=1 after E; pop at E+1; tx_o falls after E+1.
  - Frame length is exactly 10*CLKS_PER_BIT clocks from tx_o falling to the end of the stop bit.
- Throughput: consecutive frames are spaced 10*CLKS_PER_BIT clocks apart.
- The FIFO accepts a new load in the same cycle it becomes non-full.

Decomposition:
- Shared include uart_defs.vh holds:
  - FSM state encodings (2-bit: IDLE=00, START=01, DATA=10, STOP=11);
  - START_BIT=0 and STOP_BIT=1;
  - DEFAULT_CLKS_PER_BIT=868.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count.
  - Parameters FIFO_DEPTH and ADDR_W; async active-high reset.
- The FSM, bit counter and shift register stay in uart_tx_buffered.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte 0xA5 loaded when idle:
  - tx_o falls 2 clocks after load; bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks.
  - busy high for 40 clocks; idle returns to 1.
- Back-to-back 0x00 then 0xFF (loads on consecutive cycles):
  - stop bit of frame 1 is 4 clocks, followed immediately by the start bit of frame 2.
  - 80 clocks total busy, no idle gap.
- Overflow:
  - Load 6 bytes on consecutive cycles starting idle.
  - First pops after load 1, so bytes 1-5 are accepted and byte 6 is dropped; overflow=1, full=1.
  - Line carries exactly 5 frames. clr_overflow then returns overflow to 0.
- Wrap-around: 12 bytes 0x01..0x0C, each loaded when full=0; received in order via the checker with correct bit timing.
- Reset mid-frame:
  - Assert l_ready_reset during DATA bit 3.
  - tx_o=1 before the next clk edge; idle=1, full=0.
  - After release, a new byte 0x3C transmits correctly.
- Loopback: connect tx_o to uart_receive rx_i (matching bit timing); bytes 0x55, 0x80, 0x7E are recovered on data with ready pulses.
